multichannel_lock_in: RTL and testbench

Multi-channel, decimating lock-in demodulator: one quadrature reference pair (I and Q, tick-aligned upstream by the Hilbert/delay front end) is mixed against NUM_CH signal channels. Each channel's products are averaged over a 2^DECIM_LOG2-tick boxcar window. A single multiplier pair is time-shared across channels. Results stream out per channel over a valid/ready port towards the readout logic.

---
 rtl/lock_in_pkg.sv | 18 +
 rtl/lock_in_mac.sv | 69 ++++++
 rtl/multichannel_lock_in.sv | 191 +++++++++++++++++++
 tb/tb_multichannel_lock_in.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_in_pkg.sv
// Shared types and sizing helpers for the multichannel lock-in core.
package lock_in_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DUMP
  } state_t;

  function automatic int acc_width(input int nb, input int d);
    return 2 * nb + d;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lock_in_mac.sv
// Registered multiplier pair feeding a per-channel accumulator file.
module lock_in_mac
  import lock_in_pkg::*;
#(
  parameter int NUM_BITS   = 24,
  parameter int NUM_CH     = 4,
  parameter int DECIM_LOG2 = 8,
  localparam int AW = acc_width(NUM_BITS, DECIM_LOG2),
  localparam int IW = idx_width(NUM_CH)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       i_clear,
  input  logic                       i_mul_en,
  input  logic [IW-1:0]              i_sel,
  input  logic signed [NUM_BITS-1:0] i_ref_i,
  input  logic signed [NUM_BITS-1:0] i_ref_q,
  input  logic signed [NUM_BITS-1:0] i_smp,
  input  logic                       i_acc_en,
  output logic signed [AW-1:0]       o_acc_i [NUM_CH],
  output logic signed [AW-1:0]       o_acc_q [NUM_CH]
);

  localparam int PW = 2 * NUM_BITS;

  logic signed [PW-1:0] r_pi;
  logic signed [PW-1:0] r_pq;
  logic                 r_vld;
  logic [IW-1:0]        r_sel;
  logic signed [AW-1:0] r_acc_i [NUM_CH];
  logic signed [AW-1:0] r_acc_q [NUM_CH];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_pi  <= '0;
      r_pq  <= '0;
      r_vld <= 1'b0;
      r_sel <= '0;
    end else begin
      r_vld <= i_mul_en;
      if (i_mul_en) begin
        r_pi  <= PW'(i_ref_i) * PW'(i_smp);
        r_pq  <= PW'(i_ref_q) * PW'(i_smp);
        r_sel <= i_sel;
      end
    end
  end

  // Clear wins over a same-cycle accumulate.
  always_ff @(posedge clk_i) begin
    if (!reset_i || i_clear) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_acc_i[k] <= '0;
        r_acc_q[k] <= '0;
      end
    end else if (r_vld && i_acc_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (r_sel == IW'(k)) begin
          r_acc_i[k] <= r_acc_i[k] + AW'(r_pi);
          r_acc_q[k] <= r_acc_q[k] + AW'(r_pq);
        end
      end
    end
  end

  assign o_acc_i = r_acc_i;
  assign o_acc_q = r_acc_q;

endmodule

// File: rtl/multichannel_lock_in.sv
// Decimating lock-in: tick FSM, window counter, output bank
// and the per-channel valid/ready result stream.
module multichannel_lock_in
  import lock_in_pkg::*;
#(
  parameter int NUM_BITS   = 24,
  parameter int NUM_CH     = 4,
  parameter int DECIM_LOG2 = 8,
  localparam int IW = idx_width(NUM_CH)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       tick_i,
  input  logic                       enable_i,
  input  logic signed [NUM_BITS-1:0] ref_i_i,
  input  logic signed [NUM_BITS-1:0] ref_q_i,
  input  logic [NUM_CH*NUM_BITS-1:0] ch_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [IW-1:0]              out_ch_o,
  output logic                       out_last_o,
  output logic signed [NUM_BITS-1:0] x_o,
  output logic signed [NUM_BITS-1:0] y_o,
  output logic                       done_o,
  output logic                       overrun_o,
  output logic                       miss_o
);

  localparam int AW = acc_width(NUM_BITS, DECIM_LOG2);
  localparam int CW = idx_width(NUM_CH + 1);
  localparam int WW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int SH = NUM_BITS + DECIM_LOG2;
  localparam logic [CW-1:0] CNT_END = CW'(NUM_CH);
  localparam logic [IW-1:0] LAST_CH = IW'(NUM_CH - 1);
  localparam logic [WW-1:0] WIN_MAX =
    WW'((1 << DECIM_LOG2) - 1);

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]               r_cnt;
  logic [WW-1:0]               r_win;
  logic                        r_last;
  logic                        r_discard;
  logic signed [NUM_BITS-1:0]  r_ref_i;
  logic signed [NUM_BITS-1:0]  r_ref_q;
  logic [NUM_CH*NUM_BITS-1:0]  r_ch;

  logic                        r_valid;
  logic [IW-1:0]               r_out_ch;
  logic signed [NUM_BITS-1:0]  r_bank_x [NUM_CH];
  logic signed [NUM_BITS-1:0]  r_bank_y [NUM_CH];
  logic                        r_ovr;
  logic                        r_miss;

  logic                        w_accept;
  logic                        w_mul_en;
  logic [IW-1:0]               w_sel;
  logic signed [NUM_BITS-1:0]  w_smp;
  logic                        w_clear;
  logic                        w_acc_en;
  logic                        w_dump;
  logic                        w_commit;
  logic                        w_drop;
  logic                        w_xfer;
  logic signed [AW-1:0]        w_acc_i [NUM_CH];
  logic signed [AW-1:0]        w_acc_q [NUM_CH];
  logic signed [NUM_BITS-1:0]  w_x [NUM_CH];
  logic signed [NUM_BITS-1:0]  w_y [NUM_CH];

  assign w_accept = (r_state == ST_IDLE) && tick_i && enable_i;
  // Cycle CNT_END of MAC is the accumulate tail, no new product.
  assign w_mul_en = (r_state == ST_MAC) && (r_cnt != CNT_END);
  assign w_sel    = r_cnt[IW-1:0];
  assign w_smp    = r_ch[w_sel*NUM_BITS +: NUM_BITS];
  assign w_clear  = !enable_i || (r_state == ST_DUMP);
  assign w_acc_en = enable_i && !r_discard;
  assign w_dump   = (r_state == ST_DUMP) && enable_i;
  assign w_commit = w_dump && !r_valid;
  assign w_drop   = w_dump && r_valid;
  assign w_xfer   = r_valid && out_ready_i;

  lock_in_mac #(
    .NUM_BITS  (NUM_BITS),
    .NUM_CH    (NUM_CH),
    .DECIM_LOG2(DECIM_LOG2)
  ) u_mac (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_clear (w_clear),
    .i_mul_en(w_mul_en),
    .i_sel   (w_sel),
    .i_ref_i (r_ref_i),
    .i_ref_q (r_ref_q),
    .i_smp   (w_smp),
    .i_acc_en(w_acc_en),
    .o_acc_i (w_acc_i),
    .o_acc_q (w_acc_q)
  );

  for (genvar k = 0; k < NUM_CH; k++) begin : g_dump
    assign w_x[k] = NUM_BITS'(w_acc_i[k] >>> SH);
    assign w_y[k] = NUM_BITS'(w_acc_q[k] >>> SH);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_MAC;
      ST_MAC: begin
        if (r_cnt == CNT_END)
          w_next = r_last ? ST_DUMP : ST_IDLE;
      end
      ST_DUMP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_win     <= '0;
      r_last    <= 1'b0;
      r_discard <= 1'b0;
      r_ref_i   <= '0;
      r_ref_q   <= '0;
      r_ch      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ref_i   <= ref_i_i;
        r_ref_q   <= ref_q_i;
        r_ch      <= ch_i;
        r_cnt     <= '0;
        r_last    <= (r_win == WIN_MAX);
        r_win     <= (r_win == WIN_MAX) ? '0 : r_win + 1'b1;
        r_discard <= 1'b0;
      end else if (r_state == ST_MAC) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Disable aborts the window; a running MAC drains unused.
      if (!enable_i) begin
        r_win  <= '0;
        r_last <= 1'b0;
        if (r_state != ST_IDLE) r_discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_valid  <= 1'b0;
      r_out_ch <= '0;
      r_ovr    <= 1'b0;
      r_miss   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_bank_x[k] <= '0;
        r_bank_y[k] <= '0;
      end
    end else begin
      if (tick_i && (r_state != ST_IDLE)) r_miss <= 1'b1;
      if (w_drop) r_ovr <= 1'b1;
      if (w_commit) begin
        for (int k = 0; k < NUM_CH; k++) begin
          r_bank_x[k] <= w_x[k];
          r_bank_y[k] <= w_y[k];
        end
        r_valid  <= 1'b1;
        r_out_ch <= '0;
      end else if (w_xfer) begin
        if (r_out_ch == LAST_CH) begin
          r_valid  <= 1'b0;
          r_out_ch <= '0;
        end else begin
          r_out_ch <= r_out_ch + 1'b1;
        end
      end
    end
  end

  assign out_valid_o = r_valid;
  assign out_ch_o    = r_out_ch;
  assign out_last_o  = r_valid && (r_out_ch == LAST_CH);
  assign x_o         = r_bank_x[r_out_ch];
  assign y_o         = r_bank_y[r_out_ch];
  assign done_o      = w_commit;
  assign overrun_o   = r_ovr;
  assign miss_o      = r_miss;

endmodule

// File: tb/tb_multichannel_lock_in.sv
// Scoreboard bench: a cycle model predicts beats and flags.
module tb_multichannel_lock_in;

  localparam int NB = 24;
  localparam int NC = 2;
  localparam int DL = 2;
  localparam int SH = NB + DL;
  localparam int WINLEN = 1 << DL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic en = 1'b0;
  logic rdy = 1'b0;
  logic signed [NB-1:0] ri = '0;
  logic signed [NB-1:0] rq = '0;
  logic signed [NB-1:0] c0 = '0;
  logic signed [NB-1:0] c1 = '0;
  logic [NC*NB-1:0] chv;

  logic vld, last, done, ovr, miss;
  logic [0:0] och;
  logic signed [NB-1:0] xo, yo;

  assign chv = {c1, c0};

  always #5 clk = ~clk;

  multichannel_lock_in #(
    .NUM_BITS(NB), .NUM_CH(NC), .DECIM_LOG2(DL)
  ) dut (
    .clk_i(clk), .reset_i(rst_n), .tick_i(tick),
    .enable_i(en), .ref_i_i(ri), .ref_q_i(rq),
    .ch_i(chv), .out_valid_o(vld), .out_ready_i(rdy),
    .out_ch_o(och), .out_last_o(last), .x_o(xo),
    .y_o(yo), .done_o(done), .overrun_o(ovr),
    .miss_o(miss)
  );

  typedef struct {
    int     ch;
    longint x;
    longint y;
    bit     last;
  } beat_t;

  beat_t q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, act, exp);
    end
  endtask

  longint m_ai [NC];
  longint m_aq [NC];
  int     m_cnt = 0;
  int     m_pend = 0;
  int     m_done = 0;
  int     d_done = 0;
  bit     m_ovr = 0;
  bit     m_miss = 0;
  longint cyc = 0;
  longint busy_until = -1;
  longint dump_cyc = -1;

  always @(posedge clk) begin : model
    int pb;
    bit idle;
    bit fin;
    beat_t b;
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) begin
        m_ai[c] = 0;
        m_aq[c] = 0;
      end
      q.delete();
      m_cnt = 0; m_pend = 0;
      m_ovr = 0; m_miss = 0;
      busy_until = -1; dump_cyc = -1;
    end else begin
      pb = m_pend;
      idle = (cyc > busy_until);
      if (m_pend > 0 && rdy) m_pend--;
      if (cyc == dump_cyc && en) begin
        if (pb == 0) begin
          for (int c = 0; c < NC; c++) begin
            b.ch = c;
            b.x = m_ai[c] >>> SH;
            b.y = m_aq[c] >>> SH;
            b.last = (c == NC - 1);
            q.push_back(b);
          end
          m_pend = NC;
          m_done++;
        end else begin
          m_ovr = 1;
        end
        for (int c = 0; c < NC; c++) begin
          m_ai[c] = 0;
          m_aq[c] = 0;
        end
      end
      if (tick) begin
        if (!idle) m_miss = 1;
        else if (en) begin
          m_ai[0] += longint'(ri) * longint'(c0);
          m_aq[0] += longint'(rq) * longint'(c0);
          m_ai[1] += longint'(ri) * longint'(c1);
          m_aq[1] += longint'(rq) * longint'(c1);
          fin = (m_cnt == WINLEN - 1);
          m_cnt = fin ? 0 : m_cnt + 1;
          busy_until = cyc + (fin ? NC + 2 : NC + 1);
          dump_cyc = fin ? cyc + NC + 2 : -1;
        end
      end
      if (!en) begin
        for (int c = 0; c < NC; c++) begin
          m_ai[c] = 0;
          m_aq[c] = 0;
        end
        m_cnt = 0;
        dump_cyc = -1;
      end
    end
    cyc++;
  end

  logic p_vld = 1'b0;
  logic p_rdy = 1'b0;
  logic signed [NB-1:0] p_x;
  logic [0:0] p_ch;

  always @(negedge clk) begin : mon
    beat_t e;
    if (rst_n) begin
      if (done) d_done++;
      if (p_vld && !p_rdy) begin
        chk("hold_vld", vld, 1);
        chk("hold_x", xo, p_x);
        chk("hold_ch", och, p_ch);
      end
      if (vld && rdy) begin
        if (q.size() == 0) chk("spurious", 1, 0);
        else begin
          e = q.pop_front();
          chk("beat_ch", och, e.ch);
          chk("beat_x", xo, e.x);
          chk("beat_y", yo, e.y);
          chk("beat_last", last, e.last);
        end
      end
      p_vld = vld; p_rdy = rdy;
      p_x = xo; p_ch = och;
    end else begin
      p_vld = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic tick_gap(input int g);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(g - 1);
  endtask

  task automatic set_in(input int vi, input int vq,
                        input int v0, input int v1);
    ri = NB'(vi); rq = NB'(vq);
    c0 = NB'(v0); c1 = NB'(v1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || m_pend != 0 ||
            cyc <= busy_until) && k < 300) begin
      step(1);
      k++;
    end
    if (k >= 300) chk("drain_timeout", 0, 1);
    step(2);
  endtask

  task automatic en_pulse();
    en = 1'b0;
    step(1);
    en = 1'b1;
    step(1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"}, vld, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovr"}, ovr, 0);
    chk({tag, "_miss"}, miss, 0);
    chk({tag, "_x"}, xo, 0);
    chk({tag, "_y"}, yo, 0);
    chk({tag, "_ch"}, och, 0);
    chk({tag, "_last"}, last, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int d0;
    step(3);
    chk_zero("reset");
    rst_n = 1'b1; en = 1'b1; rdy = 1'b1;
    step(2);

    d0 = d_done;
    set_in(4194304, 4194304, 4194304, -4194304);
    repeat (4) tick_gap(8);
    drain();
    chk("const_done", d_done - d0, 1);

    en_pulse();
    set_in(-8388608, -8388608, -8388608, 8388607);
    repeat (4) tick_gap(8);
    drain();

    en_pulse();
    rdy = 1'b0;
    set_in(4194304, -4194304, 2097152, 1048576);
    repeat (4) tick_gap(8);
    set_in(-4194304, 4194304, 8388607, -8388608);
    repeat (4) tick_gap(8);
    step(4);
    chk("bp_ovr", ovr, 1);
    rdy = 1'b1;
    drain();

    en_pulse();
    set_in(4194304, 4194304, 0, 1048576);
    for (int i = 0; i < 16; i++) begin
      c0 = (i % 2 == 0) ? NB'(4194304) : '0;
      tick_gap(2);
    end
    c0 = '0;
    drain();
    chk("miss_flag", miss, 1);

    en_pulse();
    set_in(4194304, 4194304, 4194304, -4194304);
    tick_gap(1);
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk_zero("rst_mac");
    rdy = 1'b0;
    repeat (4) tick_gap(8);
    step(3);
    chk("pre_rst_vld", vld, 1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk_zero("rst_strm");
    rdy = 1'b1;
    step(1);
    d0 = d_done;
    repeat (4) tick_gap(8);
    drain();
    chk("clean_done", d_done - d0, 1);

    en_pulse();
    set_in(8388607, 8388607, 8388607, 8388607);
    repeat (2) tick_gap(8);
    en = 1'b0;
    step(1);
    en = 1'b1;
    set_in(2097152, -2097152, 4194304, -1048576);
    repeat (4) tick_gap(8);
    drain();

    chk("q_empty", q.size(), 0);
    chk("done_total", d_done, m_done);
    chk("ovr_final", ovr, m_ovr);
    chk("miss_final", miss, m_miss);
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
